regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: s0_valid  input  1 / s0_ready  output  1 / s0_addr  input  5 / s0_data  input  32  writeback source 0 (ALU).
REQ-004 SHALL have ports: s1_valid  input  1 / s1_ready  output  1 / s1_addr  input  5 / s1_data  input  32  writeback source 1 (load/mul unit).
REQ-005 SHALL have ports: we3  output  1 / wa3  output  5 / wd3  output  32  register file write port.
REQ-006 SHALL have ports: busy  output  1  any slot occupied; stall_cnt  output  16  saturating stall-cycle count; stat_clr  input  1  synchronous clear of stall_cnt.

Function
REQ-007 SHALL hold one slot per source (addr, data, full, age); handshake: transfer when sX_valid && sX_ready.
REQ-008 SHALL drive sX_ready = !slotX.full || grantX (slot is freed the same cycle it is granted).
REQ-009 SHALL accept a transfer with sX_addr == 0 and discard it: slot not loaded, no write issued.
REQ-010 SHALL compute the grant combinationally from slot state only; we3 = grant0 || grant1, with wa3/wd3 taken from the granted slot; when idle, wa3 = 0 and wd3 = 0.
REQ-011 SHALL give a latency of one cycle: data accepted at edge N appears on we3/wa3/wd3 during cycle N+1 and is written at edge N+2, unless it loses arbitration.
REQ-012 SHALL grant the single full slot when only one slot is full.
REQ-013 SHALL, when both slots are full with equal addr, grant the older slot first (age bit); if both were loaded on the same edge, s0 counts as older, so s1's data is written last.
REQ-014 SHALL, when both slots are full with different addr, apply the policy of REQ-021/REQ-022.
REQ-015 SHALL keep a losing slot held unchanged, with sX_ready low, until it is granted.
REQ-016 SHALL, on a transfer into an emptied slot, set that slot's age to "newer than the other slot" when the other slot is full.
REQ-017 SHALL drive busy = slot0.full || slot1.full.
REQ-018 SHALL increment stall_cnt by one per cycle in which (s0_valid && !s0_ready) || (s1_valid && !s1_ready); it saturates at 0xFFFF, and stat_clr has priority over increment.

Reset
REQ-019 SHALL, while rst_n is low, clear both slots, age bits and the RR pointer (pointing to s0) and zero stall_cnt; outputs then read we3=0, wa3=0, wd3=0, busy=0, s0_ready=s1_ready=1.
REQ-020 SHALL drop any in-flight slot contents on reset assertion mid-operation, and issue no write on the reset-release edge.

Configuration
REQ-021 SHALL, with WBARB_RR_EN defined, use round-robin on different-address conflicts: a one-bit pointer toggles to the other source after each conflict grant.
REQ-022 SHALL, without WBARB_RR_EN, use fixed priority: s0 wins every different-address conflict, with no pointer flop; REQ-013 applies in both builds.

Structure
REQ-023 SHALL import XLEN=32, REG_ADDR_W=5 and typedef wb_req_t {addr, data} from shared package regfile_pkg.
REQ-024 SHALL implement each slot as sub-module wb_skid_slot, instantiated twice; arbitration and the counter live in the top level.

Verification
REQ-025 SHALL cover: s0 writes addr=5 data=0xDEADBEEF alone -> we3=1, wa3=5, wd3=0xDEADBEEF in the next cycle; s0_ready stays 1.
REQ-026 SHALL cover: both sources valid on the same edge, addr 3/7, RR build -> writes x3 then x7 on consecutive cycles; the next conflict writes x7's source first; the fixed build writes s0 first both times.
REQ-027 SHALL cover: both sources write addr=9 on the same edge, s0=0x1, s1=0x2 -> two writes in order 0x1 then 0x2; the final value read back is 0x2.
REQ-028 SHALL cover: s1 writes addr=0 -> s1_ready=1, no we3 pulse, busy stays 0.
REQ-029 SHALL cover: s0 held valid for 4 cycles while its slot is blocked, then stat_clr -> stall_cnt counts 4, then 0; after 70000 forced stalls it holds 0xFFFF.
REQ-030 SHALL cover: rst_n pulsed low with both slots full -> all outputs at reset values immediately, and no write occurs after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types: datapath widths and the writeback request record
// exchanged between writeback sources and the register file write port.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int STAT_W     = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_skid_slot.sv
// One-entry writeback holding slot: captures a request on load, releases it on grant,
// and carries an age bit meaning "this entry is newer than the other source's entry".
module wb_skid_slot
    import regfile_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  wb_req_t load_req,
    input  logic    load_age,
    input  logic    age_clr,
    input  logic    grant,
    output logic    full,
    output wb_req_t req,
    output logic    age
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            req  <= '0;
            age  <= 1'b0;
        end else begin
            // A load on the same edge as a grant refills the slot, so load wins.
            if (load) begin
                full <= 1'b1;
            end else if (grant) begin
                full <= 1'b0;
            end

            if (load) begin
                req <= load_req;
            end

            if (load) begin
                age <= load_age;
            end else if (age_clr) begin
                age <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter in front of the register file write port.
// Define WBARB_RR_EN for round-robin on different-address conflicts; otherwise s0 has fixed priority.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [REG_ADDR_W-1:0] s0_addr,
    input  logic [XLEN-1:0]       s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [REG_ADDR_W-1:0] s1_addr,
    input  logic [XLEN-1:0]       s1_data,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] wa3,
    output logic [XLEN-1:0]       wd3,
    output logic                  busy,
    output logic [STAT_W-1:0]     stall_cnt,
    input  logic                  stat_clr
);

    logic    full0, full1;
    logic    age0, age1;
    wb_req_t req0, req1;
    logic    grant0, grant1;
    logic    load0, load1;
    logic    load_age0, load_age1;
    logic    stall;

    assign s0_ready = !full0 || grant0;
    assign s1_ready = !full1 || grant1;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign load0 = s0_valid && s0_ready && (s0_addr != '0);
    assign load1 = s1_valid && s1_ready && (s1_addr != '0);

    // A new entry is newer than the other slot if that slot stays occupied past this edge;
    // on a simultaneous load s0 is treated as the older of the two.
    assign load_age0 = full1 && !grant1;
    assign load_age1 = (full0 && !grant0) || load0;

    wb_skid_slot u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load0),
        .load_req ('{addr: s0_addr, data: s0_data}),
        .load_age (load_age0),
        .age_clr  (load1 && !load0),
        .grant    (grant0),
        .full     (full0),
        .req      (req0),
        .age      (age0)
    );

    wb_skid_slot u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load1),
        .load_req ('{addr: s1_addr, data: s1_data}),
        .load_age (load_age1),
        .age_clr  (load0 && !load1),
        .grant    (grant1),
        .full     (full1),
        .req      (req1),
        .age      (age1)
    );

`ifdef WBARB_RR_EN
    wb_src_e rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC0;
        end else if (full0 && full1 && (req0.addr != req1.addr)) begin
            rr_ptr <= (rr_ptr == SRC0) ? SRC1 : SRC0;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
            if (req0.addr == req1.addr) begin
                // Same register: the older entry must land first to preserve write order.
                grant1 = age0 && !age1;
                grant0 = !grant1;
            end else begin
`ifdef WBARB_RR_EN
                grant0 = (rr_ptr == SRC0);
                grant1 = (rr_ptr == SRC1);
`else
                grant0 = 1'b1;
`endif
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    always_comb begin
        we3 = grant0 || grant1;
        wa3 = '0;
        wd3 = '0;
        if (grant0) begin
            wa3 = req0.addr;
            wd3 = req0.data;
        end else if (grant1) begin
            wa3 = req1.addr;
            wd3 = req1.data;
        end
    end

    assign busy  = full0 || full1;
    assign stall = (s0_valid && !s0_ready) || (s1_valid && !s1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// compared against an order-of-arrival model of the two writeback sources.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [4:0]  s0_addr, s1_addr, wa3;
    logic [31:0] s0_data, s1_data, wd3;
    logic        we3, busy, stat_clr;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each source holds at most one pending write, stamped with its arrival order.
    logic        m_full [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    int unsigned m_seq  [2];
    int unsigned seq_ctr;
    logic        m_ptr;
    int          m_cnt;
    logic [31:0] m_rf   [32];
    logic [31:0] dut_rf [32];

    logic        exp_we, exp_rdy0, exp_rdy1, exp_busy;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s0_addr   (s0_addr),
        .s0_data   (s0_data),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_addr   (s1_addr),
        .s1_data   (s1_data),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .stat_clr  (stat_clr)
    );

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        seq_ctr   = 0;
        m_ptr     = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic drive_idle();
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
        stat_clr = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs after the falling edge, snapshot model expectations,
    // then advance the model across the coming rising edge.
    task automatic tick(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic clr);
        int   g;
        logic stall;
        @(negedge clk);
        s0_valid = v0; s0_addr = a0; s0_data = d0;
        s1_valid = v1; s1_addr = a1; s1_data = d1;
        stat_clr = clr;
        #1;
        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) begin
                g = (m_seq[0] < m_seq[1]) ? 0 : 1;
            end else begin
`ifdef WBARB_RR_EN
                g     = m_ptr ? 1 : 0;
                m_ptr = !m_ptr;
`else
                g = 0;
`endif
            end
        end else if (m_full[0]) begin
            g = 0;
        end else if (m_full[1]) begin
            g = 1;
        end
        exp_we   = (g >= 0);
        exp_wa   = (g >= 0) ? m_addr[g] : 5'd0;
        exp_wd   = (g >= 0) ? m_data[g] : 32'd0;
        exp_rdy0 = !m_full[0] || (g == 0);
        exp_rdy1 = !m_full[1] || (g == 1);
        exp_busy = m_full[0] || m_full[1];
        exp_cnt  = m_cnt[15:0];
        stall    = (v0 && !exp_rdy0) || (v1 && !exp_rdy1);
        if (we3) dut_rf[wa3] = wd3;
        if (clr)                        m_cnt = 0;
        else if (stall && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (g >= 0) begin
            m_rf[m_addr[g]] = m_data[g];
            m_full[g] = 1'b0;
        end
        if (v0 && exp_rdy0 && a0 != 0) begin
            m_full[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_seq[0] = seq_ctr; seq_ctr++;
        end
        if (v1 && exp_rdy1 && a1 != 0) begin
            m_full[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_seq[1] = seq_ctr; seq_ctr++;
        end
    endtask

    task automatic idle_tick();
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #2;
        n_checks++;
        if ({we3, wa3, wd3, busy, s0_ready, s1_ready, stall_cnt} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 16'd0}) begin
            n_errors++;
            $display("FAIL reset_values we3=%b wa3=%0d wd3=%h busy=%b rdy=%b%b cnt=%0d, want 0/0/0/0/11/0",
                     we3, wa3, wd3, busy, s0_ready, s1_ready, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_write();
        apply_reset();
        tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        n_checks++;
        if (s0_ready !== 1'b1 || we3 !== 1'b0) begin
            n_errors++;
            $display("FAIL single_accept s0_ready=%b we3=%b, want 1/0", s0_ready, we3);
        end
        idle_tick();
        n_checks++;
        if ({we3, wa3, wd3, s0_ready} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            n_errors++;
            $display("FAIL single_write we3=%b wa3=%0d wd3=%h s0_ready=%b, want 1/5/deadbeef/1",
                     we3, wa3, wd3, s0_ready);
        end
        idle_tick();
        n_checks++;
        if (we3 !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_drain we3=%b busy=%b, want 0/0", we3, busy);
        end
    endtask

    task automatic test_conflict();
        logic [4:0] first2, second2;
`ifdef WBARB_RR_EN
        first2 = 5'd7; second2 = 5'd3;
`else
        first2 = 5'd3; second2 = 5'd7;
`endif
        apply_reset();
        tick(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB0B0_0007, 1'b0);
        idle_tick();
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd3 || s1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL conflict1_first we3=%b wa3=%0d s1_ready=%b, want 1/3/0", we3, wa3, s1_ready);
        end
        idle_tick();
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'hB0B0_0007) begin
            n_errors++;
            $display("FAIL conflict1_second we3=%b wa3=%0d wd3=%h, want 1/7/b0b00007", we3, wa3, wd3);
        end
        tick(1'b1, 5'd3, 32'hC0C0_0003, 1'b1, 5'd7, 32'hD0D0_0007, 1'b0);
        idle_tick();
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== first2) begin
            n_errors++;
            $display("FAIL conflict2_first we3=%b wa3=%0d, want 1/%0d", we3, wa3, first2);
        end
        idle_tick();
        n_checks++;
        if (we3 !== 1'b1 || wa3 !== second2) begin
            n_errors++;
            $display("FAIL conflict2_second we3=%b wa3=%0d, want 1/%0d", we3, wa3, second2);
        end
    endtask

    task automatic test_same_addr();
        apply_reset();
        tick(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0);
        idle_tick();
        n_checks++;
        if ({we3, wa3, wd3} !== {1'b1, 5'd9, 32'h1}) begin
            n_errors++;
            $display("FAIL same_addr_first we3=%b wa3=%0d wd3=%h, want 1/9/1", we3, wa3, wd3);
        end
        idle_tick();
        n_checks++;
        if ({we3, wa3, wd3} !== {1'b1, 5'd9, 32'h2}) begin
            n_errors++;
            $display("FAIL same_addr_second we3=%b wa3=%0d wd3=%h, want 1/9/2", we3, wa3, wd3);
        end
        idle_tick();
        n_checks++;
        if (dut_rf[9] !== 32'h2) begin
            n_errors++;
            $display("FAIL same_addr_final x9=%h, want 2", dut_rf[9]);
        end
    endtask

    task automatic test_addr_zero();
        apply_reset();
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0);
        n_checks++;
        if (s1_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL x0_ready s1_ready=%b, want 1", s1_ready);
        end
        idle_tick();
        n_checks++;
        if (we3 !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL x0_discard we3=%b busy=%b, want 0/0", we3, busy);
        end
    endtask

    // Both sources hammer one register so that one of them stalls on every cycle after the first.
    task automatic test_stall_counter();
        apply_reset();
        repeat (5) tick(1'b1, 5'd4, $urandom, 1'b1, 5'd4, $urandom, 1'b0);
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_checks++;
        if (stall_cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL stall_count got=%0d want=4", stall_cnt);
        end
        idle_tick();
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL stall_clear got=%0d want=0", stall_cnt);
        end
        idle_tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (70000) tick(1'b1, 5'd6, $urandom, 1'b1, 5'd6, $urandom, 1'b0);
        idle_tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF || exp_cnt !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL stall_saturate got=%h model=%h want=ffff", stall_cnt, exp_cnt);
        end
        repeat (2) idle_tick();
    endtask

    task automatic test_random();
        logic [4:0] pool [4];
        pool[0] = 5'd0; pool[1] = 5'd3; pool[2] = 5'd9; pool[3] = 5'd17;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, pool[$urandom_range(0, 3)], $urandom,
                 $urandom_range(0, 3) != 0, pool[$urandom_range(0, 3)], $urandom,
                 $urandom_range(0, 31) == 0);
            n_checks++;
            if ({we3, wa3, wd3} !== {exp_we, exp_wa, exp_wd}) begin
                n_errors++;
                $display("FAIL rand_write cyc=%0d got=%b/%0d/%h want=%b/%0d/%h",
                         i, we3, wa3, wd3, exp_we, exp_wa, exp_wd);
            end
            n_checks++;
            if ({s0_ready, s1_ready, busy} !== {exp_rdy0, exp_rdy1, exp_busy}) begin
                n_errors++;
                $display("FAIL rand_status cyc=%0d rdy/busy got=%b%b%b want=%b%b%b",
                         i, s0_ready, s1_ready, busy, exp_rdy0, exp_rdy1, exp_busy);
            end
            n_checks++;
            if (stall_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL rand_stall cyc=%0d got=%0d want=%0d", i, stall_cnt, exp_cnt);
            end
        end
        repeat (3) idle_tick();
        for (int r = 0; r < 32; r++) begin
            n_checks++;
            if (dut_rf[r] !== m_rf[r]) begin
                n_errors++;
                $display("FAIL rand_regfile x%0d got=%h want=%h", r, dut_rf[r], m_rf[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd8, 32'h8888_8888, 1'b0);
        @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_setup busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({we3, wa3, wd3, busy, s0_ready, s1_ready, stall_cnt} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 16'd0}) begin
            n_errors++;
            $display("FAIL midreset_values we3=%b wa3=%0d wd3=%h busy=%b rdy=%b%b cnt=%0d",
                     we3, wa3, wd3, busy, s0_ready, s1_ready, stall_cnt);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            n_checks++;
            if (we3 !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_nowrite cyc=%0d we3=%b busy=%b, want 0/0", i, we3, busy);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_rf[r]   = 32'd0;
            dut_rf[r] = 32'd0;
        end
        model_reset();
        test_reset();
        test_single_write();
        test_conflict();
        test_same_addr();
        test_addr_zero();
        test_stall_counter();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
